// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline and the hazard controller: stage status
// flows in, stall/flush/multi-cycle controls and debug status flow out.
interface hazard_ctrl_if;
    // ID stage operands
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_is_store;

    // EX / MEM stage status
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_mc_op;
    logic        ex_br_taken;
    logic        me_mem_req;
    logic        dmem_ready;

    // Pipeline register controls
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_stall;
    logic        ex_me_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_me_flush;
    logic        me_wb_flush;
    logic        mc_done;

    // Observability
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    // Pipeline side: drives stage status, consumes controls.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_store,
        output ex_rd, ex_mem_read, ex_mc_op, ex_br_taken,
        output me_mem_req, dmem_ready,
        input  pc_stall, if_id_stall, id_ex_stall, ex_me_stall,
        input  if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush,
        input  mc_done, state, stall_cnt
    );

    // Hazard controller side.
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_store,
        input  ex_rd, ex_mem_read, ex_mc_op, ex_br_taken,
        input  me_mem_req, dmem_ready,
        output pc_stall, if_id_stall, id_ex_stall, ex_me_stall,
        output if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush,
        output mc_done, state, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use interlock, taken-branch flush,
// multi-cycle EX hold and data-memory wait, with a saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned MC_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rstn,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MC_BUSY  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_UNUSED   = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_me_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_me_flush;
        logic me_wb_flush;
        logic mc_done;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{
        pc_stall: 1'b0, if_id_stall: 1'b0, id_ex_stall: 1'b0, ex_me_stall: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_me_flush: 1'b0, me_wb_flush: 1'b0,
        mc_done: 1'b0
    };

    // Freeze everything up to MEM; MEM/WB takes a bubble while memory is busy.
    localparam ctrl_t CTRL_MEM_HOLD = '{
        pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b1, ex_me_stall: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_me_flush: 1'b0, me_wb_flush: 1'b1,
        mc_done: 1'b0
    };

    localparam ctrl_t CTRL_BRANCH = '{
        pc_stall: 1'b0, if_id_stall: 1'b0, id_ex_stall: 1'b0, ex_me_stall: 1'b0,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_me_flush: 1'b0, me_wb_flush: 1'b0,
        mc_done: 1'b0
    };

    // EX holds its op; EX/MEM takes a bubble so MEM never sees a half-done result.
    localparam ctrl_t CTRL_MC_HOLD = '{
        pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b1, ex_me_stall: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_me_flush: 1'b1, me_wb_flush: 1'b0,
        mc_done: 1'b0
    };

    localparam ctrl_t CTRL_LOAD_USE = '{
        pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b0, ex_me_stall: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_me_flush: 1'b0, me_wb_flush: 1'b0,
        mc_done: 1'b0
    };

    localparam ctrl_t CTRL_MC_DONE = '{
        pc_stall: 1'b0, if_id_stall: 1'b0, id_ex_stall: 1'b0, ex_me_stall: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_me_flush: 1'b0, me_wb_flush: 1'b0,
        mc_done: 1'b1
    };

    // First hold cycle happens in RUN, so the counter covers the remaining ones.
    localparam logic [7:0]  MC_LOAD   = 8'(MC_CYCLES - 1);
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_stall_cnt;

    state_t      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    ctrl_t       w_ctrl;
    logic        w_mem_wait;
    logic        w_load_use;
    logic        w_rs1_hit;
    logic        w_rs2_hit;

    assign w_mem_wait = hz.me_mem_req && !hz.dmem_ready;

    // Store data in rs2 is forwarded in MEM, so only a non-store rs2 read interlocks.
    assign w_rs1_hit  = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
    assign w_rs2_hit  = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd) && !hz.id_is_store;
    assign w_load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can infer a latch.
        w_ctrl      = CTRL_NONE;
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 8'd0;

        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) begin
                    w_ctrl      = CTRL_MEM_HOLD;
                    w_state_nxt = ST_MEM_WAIT;
                end else if (hz.ex_br_taken) begin
                    w_ctrl      = CTRL_BRANCH;
                end else if (hz.ex_mc_op) begin
                    w_ctrl      = CTRL_MC_HOLD;
                    w_cnt_nxt   = MC_LOAD;
                    w_state_nxt = ST_MC_BUSY;
                end else if (w_load_use) begin
                    w_ctrl      = CTRL_LOAD_USE;
                end
            end

            // MEM carries a bubble here, so memory status, branches and
            // load-use are irrelevant until the op completes.
            ST_MC_BUSY: begin
                if (r_cnt != 8'd0) begin
                    w_ctrl      = CTRL_MC_HOLD;
                    w_cnt_nxt   = r_cnt - 8'd1;
                    w_state_nxt = ST_MC_BUSY;
                end else begin
                    w_ctrl      = CTRL_MC_DONE;
                end
            end

            // Held EX instruction is re-evaluated in RUN once memory completes.
            ST_MEM_WAIT: begin
                if (w_mem_wait) begin
                    w_ctrl      = CTRL_MEM_HOLD;
                    w_state_nxt = ST_MEM_WAIT;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // Reset must silence the pipeline controls even before the state settles.
        if (!rstn) begin
            w_ctrl = CTRL_NONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_RUN;
            r_cnt       <= 8'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_ctrl.pc_stall && (r_stall_cnt != STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign hz.pc_stall    = w_ctrl.pc_stall;
    assign hz.if_id_stall = w_ctrl.if_id_stall;
    assign hz.id_ex_stall = w_ctrl.id_ex_stall;
    assign hz.ex_me_stall = w_ctrl.ex_me_stall;
    assign hz.if_id_flush = w_ctrl.if_id_flush;
    assign hz.id_ex_flush = w_ctrl.id_ex_flush;
    assign hz.ex_me_flush = w_ctrl.ex_me_flush;
    assign hz.me_wb_flush = w_ctrl.me_wb_flush;
    assign hz.mc_done     = w_ctrl.mc_done;
    assign hz.state       = r_state;
    assign hz.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MC_CYCLES = 4): expected controls,
// state and stall count are queued per cycle and compared on the falling edge.
module tb_hazard_ctrl;

    // Control vector order: pc, if_id, id_ex, ex_me stalls; if_id, id_ex, ex_me, me_wb flushes; mc_done
    localparam logic [8:0] C_NONE = 9'b0000_0000_0;
    localparam logic [8:0] C_MEMW = 9'b1111_0001_0;
    localparam logic [8:0] C_BR   = 9'b0000_1100_0;
    localparam logic [8:0] C_MC   = 9'b1110_0010_0;
    localparam logic [8:0] C_LU   = 9'b1100_0100_0;
    localparam logic [8:0] C_DONE = 9'b0000_0000_1;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_MC  = 2'd1;
    localparam logic [1:0] S_MW  = 2'd2;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [1:0]  state;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rstn;
    int          n_cmp;
    int          n_fail;
    logic [15:0] exp_cnt;
    exp_t        sb_q[$];
    string       tag_q[$];

    hazard_ctrl_if hz_if ();

    hazard_ctrl #(.MC_CYCLES(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hz_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_in();
        hz_if.id_rs1      = 5'd0;
        hz_if.id_rs2      = 5'd0;
        hz_if.id_use_rs1  = 1'b0;
        hz_if.id_use_rs2  = 1'b0;
        hz_if.id_is_store = 1'b0;
        hz_if.ex_rd       = 5'd0;
        hz_if.ex_mem_read = 1'b0;
        hz_if.ex_mc_op    = 1'b0;
        hz_if.ex_br_taken = 1'b0;
        hz_if.me_mem_req  = 1'b0;
        hz_if.dmem_ready  = 1'b0;
    endtask

    task automatic check();
        exp_t       e;
        string      t;
        logic [8:0] o_ctrl;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        o_ctrl = {hz_if.pc_stall, hz_if.if_id_stall, hz_if.id_ex_stall, hz_if.ex_me_stall,
                  hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.ex_me_flush, hz_if.me_wb_flush,
                  hz_if.mc_done};
        n_cmp++;
        assert (o_ctrl === e.ctrl) else begin
            n_fail++;
            $error("FAIL %s.ctrl: observed %b expected %b", t, o_ctrl, e.ctrl);
        end
        n_cmp++;
        assert (hz_if.state === e.state) else begin
            n_fail++;
            $error("FAIL %s.state: observed %0d expected %0d", t, hz_if.state, e.state);
        end
        n_cmp++;
        assert (hz_if.stall_cnt === e.cnt) else begin
            n_fail++;
            $error("FAIL %s.stall_cnt: observed %h expected %h", t, hz_if.stall_cnt, e.cnt);
        end
    endtask

    // One clock cycle: queue the expectation for the inputs just driven, compare
    // mid-cycle, advance the stall-count model, then move just past the next edge.
    task automatic step(input string tag, input logic [8:0] e_ctrl, input logic [1:0] e_state);
        exp_t e;
        e.ctrl  = e_ctrl;
        e.state = e_state;
        e.cnt   = exp_cnt;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check();
        if (e_ctrl[8] && rstn && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        exp_cnt = 16'd0;
        rstn    = 1'b0;
        clear_in();

        // Reset overrides hostile inputs
        @(posedge clk);
        #1;
        hz_if.me_mem_req = 1'b1;
        hz_if.ex_mc_op   = 1'b1;
        step("rst_hostile0", C_NONE, S_RUN);
        step("rst_hostile1", C_NONE, S_RUN);
        clear_in();
        rstn = 1'b1;
        step("idle", C_NONE, S_RUN);

        // Load-use on rs1
        hz_if.ex_mem_read = 1'b1;
        hz_if.ex_rd       = 5'd5;
        hz_if.id_rs1      = 5'd5;
        hz_if.id_use_rs1  = 1'b1;
        step("lu_rs1", C_LU, S_RUN);
        hz_if.id_use_rs1  = 1'b0;
        step("lu_rs1_unused", C_NONE, S_RUN);

        // Store data on rs2 does not interlock; a plain rs2 read does
        hz_if.id_rs1      = 5'd7;
        hz_if.id_rs2      = 5'd5;
        hz_if.id_use_rs2  = 1'b1;
        hz_if.id_is_store = 1'b1;
        step("lu_store_rs2", C_NONE, S_RUN);
        hz_if.id_is_store = 1'b0;
        step("lu_rs2", C_LU, S_RUN);

        // Load to x0 never interlocks
        clear_in();
        hz_if.ex_mem_read = 1'b1;
        hz_if.id_use_rs1  = 1'b1;
        step("lu_x0", C_NONE, S_RUN);

        // Branch, and branch beating multi-cycle and load-use
        clear_in();
        hz_if.ex_br_taken = 1'b1;
        step("branch", C_BR, S_RUN);
        hz_if.ex_mc_op    = 1'b1;
        hz_if.ex_mem_read = 1'b1;
        hz_if.ex_rd       = 5'd3;
        hz_if.id_rs1      = 5'd3;
        hz_if.id_use_rs1  = 1'b1;
        step("prio_br", C_BR, S_RUN);

        // Multi-cycle op: 4 hold cycles then mc_done; MC_BUSY masks other hazards
        clear_in();
        hz_if.ex_mc_op = 1'b1;
        step("mc_c1", C_MC, S_RUN);
        hz_if.ex_br_taken = 1'b1;
        hz_if.me_mem_req  = 1'b1;
        hz_if.ex_mem_read = 1'b1;
        hz_if.ex_rd       = 5'd9;
        hz_if.id_rs1      = 5'd9;
        hz_if.id_use_rs1  = 1'b1;
        step("mc_c2_masked", C_MC, S_MC);
        clear_in();
        hz_if.ex_mc_op = 1'b1;
        step("mc_c3", C_MC, S_MC);
        step("mc_c4", C_MC, S_MC);
        step("mc_done", C_DONE, S_MC);
        hz_if.ex_mc_op = 1'b0;
        step("mc_exit", C_NONE, S_RUN);

        // Memory wait with a pending branch; mem_wait beats multi-cycle too
        hz_if.me_mem_req  = 1'b1;
        hz_if.ex_br_taken = 1'b1;
        step("mw_c1", C_MEMW, S_RUN);
        step("mw_c2", C_MEMW, S_MW);
        step("mw_c3", C_MEMW, S_MW);
        hz_if.dmem_ready = 1'b1;
        step("mw_ready", C_NONE, S_MW);
        hz_if.me_mem_req = 1'b0;
        hz_if.dmem_ready = 1'b0;
        step("mw_branch", C_BR, S_RUN);
        clear_in();
        hz_if.me_mem_req = 1'b1;
        hz_if.ex_mc_op   = 1'b1;
        step("prio_mw", C_MEMW, S_RUN);
        hz_if.dmem_ready = 1'b1;
        hz_if.ex_mc_op   = 1'b0;
        step("prio_mw_exit", C_NONE, S_MW);
        clear_in();

        // Reset in the middle of MC_BUSY with counter at 2
        hz_if.ex_mc_op = 1'b1;
        step("rmc_c1", C_MC, S_RUN);
        step("rmc_c2", C_MC, S_MC);
        rstn    = 1'b0;
        exp_cnt = 16'd0;
        step("rmc_reset", C_NONE, S_RUN);
        hz_if.ex_mc_op = 1'b0;
        rstn = 1'b1;
        step("rmc_after0", C_NONE, S_RUN);
        step("rmc_after1", C_NONE, S_RUN);
        step("rmc_after2", C_NONE, S_RUN);

        // Saturation of stall_cnt under a long memory wait
        hz_if.me_mem_req = 1'b1;
        step("sat_enter", C_MEMW, S_RUN);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        #1;
        step("sat_full", C_MEMW, S_MW);
        step("sat_hold", C_MEMW, S_MW);
        hz_if.dmem_ready = 1'b1;
        step("sat_ready", C_NONE, S_MW);
        clear_in();
        step("sat_run", C_NONE, S_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter MC_CYCLES, default 4, range 1..255: number of extra cycles a multi-cycle EX op (mul/div) holds EX.
REQ-002 SHALL use one clock and an asynchronous, active-low reset:
  clk            in   1   rising-edge clock
  rstn           in   1   asynchronous active-low reset
  id_rs1         in   5   ID-stage source register 1
  id_rs2         in   5   ID-stage source register 2
  id_use_rs1     in   1   ID instruction reads rs1
  id_use_rs2     in   1   ID instruction reads rs2
  id_is_store    in   1   ID instruction is a store (rs2 = store data)
  ex_rd          in   5   EX-stage destination register
  ex_mem_read    in   1   EX instruction is a load
  ex_mc_op       in   1   EX instruction is a multi-cycle op
  ex_br_taken    in   1   EX branch/jump resolved taken
  me_mem_req     in   1   MEM stage issues a data-memory access
  dmem_ready     in   1   data memory completes access this cycle
  pc_stall       out  1   hold PC
  if_id_stall    out  1   hold IF/ID register
  id_ex_stall    out  1   hold ID/EX register
  ex_me_stall    out  1   hold EX/MEM register
  if_id_flush    out  1   load bubble into IF/ID
  id_ex_flush    out  1   load bubble into ID/EX
  ex_me_flush    out  1   load bubble into EX/MEM
  me_wb_flush    out  1   load bubble into MEM/WB
  mc_done        out  1   multi-cycle op result valid, EX may advance
  state          out  2   FSM state (RUN=0, MC_BUSY=1, MEM_WAIT=2)
  stall_cnt      out  16  cycles with pc_stall=1, saturating

Function
REQ-003 SHALL implement FSM states RUN, MC_BUSY, MEM_WAIT; encoding 3 unused, SHALL return to RUN next cycle if entered.
REQ-004 SHALL define mem_wait = me_mem_req && !dmem_ready.
REQ-005 SHALL define load_use = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd && !id_is_store)); store-data rs2 match SHALL NOT stall (covered by MEM-stage store-data forwarding).
REQ-006 In RUN, SHALL evaluate in priority: mem_wait > ex_br_taken > ex_mc_op > load_use > none.
REQ-007 RUN & mem_wait: SHALL assert pc/if_id/id_ex/ex_me stall and me_wb_flush, no other flush; next state MEM_WAIT.
REQ-008 RUN & ex_br_taken: SHALL assert if_id_flush and id_ex_flush, no stalls; stay RUN.
REQ-009 RUN & ex_mc_op: SHALL assert pc/if_id/id_ex stall and ex_me_flush; load down-counter with MC_CYCLES-1; next state MC_BUSY.
REQ-010 RUN & load_use: SHALL assert pc_stall, if_id_stall, id_ex_flush for exactly that cycle; stay RUN.
REQ-011 MC_BUSY: counter!=0 -> same outputs as REQ-009, decrement; counter==0 -> mc_done=1, all stalls/flushes 0, next state RUN.
REQ-012 MC_BUSY SHALL ignore me_mem_req/dmem_ready (MEM holds a bubble); ex_br_taken and load_use SHALL be masked.
REQ-013 MEM_WAIT: outputs as REQ-007 while mem_wait; when dmem_ready=1 all outputs 0, next state RUN; branch/mc/load-use in held EX re-evaluated in RUN after exit.
REQ-014 All stall/flush/mc_done outputs SHALL be combinational from state, counter and inputs; state, counter, stall_cnt SHALL be registered.
REQ-015 stall_cnt SHALL increment by 1 on each rising edge where pc_stall=1, saturating at 16'hFFFF (no wrap).
REQ-016 Total EX occupancy of a multi-cycle op SHALL be MC_CYCLES+1 cycles, mc_done high in the last.

Reset
REQ-017 rstn=0 SHALL immediately force state=RUN, counter=0, stall_cnt=0, and all stall/flush/mc_done outputs to 0 regardless of inputs.
REQ-018 Reset deassertion mid-MC_BUSY or MEM_WAIT SHALL resume in RUN with no mc_done pulse.

Verification
REQ-019 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_stall=if_id_stall=id_ex_flush=1, stall_cnt 0->1; with id_is_store=1, only rs2=5 match -> no stall.
REQ-020 x0 load: ex_rd=0, id_rs1=0 -> no stall, state stays RUN.
REQ-021 MC_CYCLES=4, ex_mc_op held -> stalls 4 cycles, mc_done=1 in 5th, state 0,1,1,1,1,0; stall_cnt=4.
REQ-022 mem_wait 3 cycles with ex_br_taken=1 -> no flush in cycles 1-3, state MEM_WAIT; after dmem_ready, RUN cycle with if_id_flush=id_ex_flush=1.
REQ-023 Saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF, holds.
REQ-024 Assert rstn=0 mid-MC_BUSY (counter=2) -> outputs 0 same cycle, state=RUN, no mc_done after release.
